// File: rtl/output_line_buffer_pkg.sv
// Shared constants, state encoding and beat helpers for the output line buffer.
package output_line_buffer_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int MAX_IMAGE_SIZE = 128;
   localparam int FIFO_DEPTH_DEF = MAX_IMAGE_SIZE;
   localparam int PTR_WIDTH_DEF  = $clog2(FIFO_DEPTH_DEF);
   localparam int CNT_WIDTH      = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // A beat closes the frame when it is the final beat of a row flagged as last.
   function automatic logic is_last_beat(input logic [CNT_WIDTH-1:0] idx,
                                         input logic [CNT_WIDTH-1:0] len,
                                         input logic                 flag);
      return flag && (idx == (len - 8'd1));
   endfunction

endpackage

// File: rtl/output_line_buffer_if.sv
// AXI4-Stream pixel channel leaving the output line buffer.
interface output_line_buffer_if #(
   parameter int DATA_WIDTH = output_line_buffer_pkg::DATA_WIDTH_DEF
) ();

   logic signed [DATA_WIDTH-1:0] tdata;
   logic                         tvalid;
   logic                         tready;
   logic                         tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/output_line_fifo.sv
// Row FIFO with first-word fall-through read; storage maps onto distributed RAM.
module output_line_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 128,
   parameter int PTR_WIDTH  = 7
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [PTR_WIDTH:0]    count_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH:0]    count_q, count_d;
   logic                  push_ok_s;
   logic                  pop_ok_s;

   assign full_o    = (count_q == (PTR_WIDTH+1)'(DEPTH));
   assign empty_o   = (count_q == (PTR_WIDTH+1)'(0));
   assign count_o   = count_q;
   assign rdata_o   = mem_q[rd_ptr_q];
   assign push_ok_s = push_i && !full_o;
   assign pop_ok_s  = pop_i && !empty_o;

   // Storage write port (no reset so it maps onto RAM).
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointer and occupancy next state; pointers wrap because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + (PTR_WIDTH+1)'(1);
         2'b01:   count_d = count_q - (PTR_WIDTH+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/output_line_buffer.sv
// Buffers one conv output row and replays it as an AXI4-Stream master with a registered output stage.
module output_line_buffer
   import output_line_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int PTR_WIDTH  = PTR_WIDTH_DEF
) (
   input  logic                         clk,
   input  logic                         Reset_n,
   input  logic signed [DATA_WIDTH-1:0] din,
   input  logic                         din_valid,
   output logic                         din_ready,
   input  logic                         Start_row,
   input  logic [CNT_WIDTH-1:0]         IMAGE_SIZE,
   input  logic                         last_row,
   output_line_buffer_if.master         m_axis,
   output logic                         Done_1row,
   output logic                         Busy
);

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   row_len_q, row_len_d;
   logic                   last_flag_q, last_flag_d;
   logic [CNT_WIDTH-1:0]   in_cnt_q, in_cnt_d;
   logic [CNT_WIDTH-1:0]   out_cnt_q, out_cnt_d;
   logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
   logic                   tvalid_q, tvalid_d;
   logic                   tlast_q, tlast_d;

   logic                   push_s;
   logic                   pop_s;
   logic                   hs_s;
   logic [DATA_WIDTH-1:0]  fifo_rdata_s;
   logic                   fifo_full_s;
   logic                   fifo_empty_s;
   logic [PTR_WIDTH:0]     fifo_count_s;

   output_line_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH),
      .PTR_WIDTH  (PTR_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (Reset_n),
      .push_i  (push_s),
      .wdata_i (din),
      .pop_i   (pop_s),
      .rdata_o (fifo_rdata_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .count_o (fifo_count_s)
   );

   assign din_ready = (state_q == ST_STREAM) && (in_cnt_q < row_len_q) && !fifo_full_s;
   assign push_s    = din_valid && din_ready;
   assign hs_s      = tvalid_q && m_axis.tready;
   // The output register refills whenever it is empty or being consumed this cycle.
   assign pop_s     = (fifo_count_s != (PTR_WIDTH+1)'(0)) && (!tvalid_q || hs_s);

   assign m_axis.tdata  = tdata_q;
   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tlast  = tlast_q;
   assign Done_1row     = (state_q == ST_DONE);
   assign Busy          = (state_q != ST_IDLE);

   // Row control: next state and per-row counters.
   always_comb begin
      state_d     = state_q;
      row_len_d   = row_len_q;
      last_flag_d = last_flag_q;
      in_cnt_d    = push_s ? (in_cnt_q + 8'd1) : in_cnt_q;
      out_cnt_d   = hs_s ? (out_cnt_q + 8'd1) : out_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (Start_row && (IMAGE_SIZE != 8'd0)) begin
               row_len_d   = IMAGE_SIZE;
               last_flag_d = last_row;
               in_cnt_d    = 8'd0;
               out_cnt_d   = 8'd0;
               state_d     = ST_STREAM;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_STREAM: begin
            if (push_s && (in_cnt_d == row_len_q)) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_STREAM;
            end
         end
         ST_DRAIN: begin
            if ((out_cnt_q == row_len_q) && fifo_empty_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output register: the index of a newly loaded beat equals the post-handshake out count.
   always_comb begin
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      if (pop_s) begin
         tdata_d  = fifo_rdata_s;
         tvalid_d = 1'b1;
         tlast_d  = is_last_beat(out_cnt_d, row_len_q, last_flag_q);
      end else if (hs_s) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
      end else begin
         tvalid_d = tvalid_q;
      end
   end

   // State, counter and output registers.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= ST_IDLE;
         row_len_q   <= 8'd0;
         last_flag_q <= 1'b0;
         in_cnt_q    <= 8'd0;
         out_cnt_q   <= 8'd0;
         tdata_q     <= '0;
         tvalid_q    <= 1'b0;
         tlast_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_len_q   <= row_len_d;
         last_flag_q <= last_flag_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         tdata_q     <= tdata_d;
         tvalid_q    <= tvalid_d;
         tlast_q     <= tlast_d;
      end
   end

endmodule

// File: tb/tb_output_line_buffer.sv
// Randomized scoreboard bench for output_line_buffer: rows are modelled as pixel lists with a frame-end marker.
module tb_output_line_buffer;
   import output_line_buffer_pkg::*;

   localparam int DW = 16;

   logic                 clk = 1'b0;
   logic                 Reset_n = 1'b0;
   logic signed [DW-1:0] din;
   logic                 din_valid;
   logic                 din_ready;
   logic                 Start_row;
   logic [7:0]           IMAGE_SIZE;
   logic                 last_row;
   logic                 Done_1row;
   logic                 Busy;

   output_line_buffer_if #(.DATA_WIDTH(DW)) axis_if ();

   output_line_buffer dut (
      .clk        (clk),
      .Reset_n    (Reset_n),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .Start_row  (Start_row),
      .IMAGE_SIZE (IMAGE_SIZE),
      .last_row   (last_row),
      .m_axis     (axis_if),
      .Done_1row  (Done_1row),
      .Busy       (Busy)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [DW:0] exp_q[$];
   int          len_q[$];
   int          hs_cyc[$];
   int          push_cyc[$];
   logic [DW-1:0] pix[$];
   int          done_cnt = 0;
   int          beats_in_row = 0;
   int          rdy_mode = 3;
   logic        prev_stall = 1'b0;
   logic        prev_done = 1'b0;
   logic [DW:0] prev_beat = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // tready pattern: 0 = always ready, 1 = random, 2 = toggle, other = never ready
   initial begin
      axis_if.tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       axis_if.tready = 1'b1;
            1:       axis_if.tready = ($urandom_range(0, 2) != 0);
            2:       axis_if.tready = ~axis_if.tready;
            default: axis_if.tready = 1'b0;
         endcase
      end
   end

   // Monitor: scoreboard pops on every handshake, plus stability and row-completion checks.
   always @(negedge clk) begin
      logic [DW:0] e;
      int          l;
      if (!Reset_n) begin
         prev_stall = 1'b0;
         prev_done  = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (!(axis_if.tvalid && ({axis_if.tlast, axis_if.tdata} == prev_beat))) begin
               errors++;
               $display("FAIL hold_stable: tvalid=%0b last/data=%h, required held %h",
                        axis_if.tvalid, {axis_if.tlast, axis_if.tdata}, prev_beat);
            end
         end
         if (axis_if.tvalid && axis_if.tready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL extra_beat: got last/data=%h, required no beat", {axis_if.tlast, axis_if.tdata});
            end else begin
               e = exp_q.pop_front();
               if ({axis_if.tlast, axis_if.tdata} !== e) begin
                  errors++;
                  $display("FAIL beat: got last/data=%h, required %h", {axis_if.tlast, axis_if.tdata}, e);
               end
            end
            beats_in_row++;
            hs_cyc.push_back(cyc);
         end
         prev_stall = axis_if.tvalid && !axis_if.tready;
         prev_beat  = {axis_if.tlast, axis_if.tdata};
         if (Done_1row) begin
            checks++;
            if (prev_done) begin
               errors++;
               $display("FAIL done_pulse: Done_1row high 2 cycles, required 1");
            end else if (len_q.size() == 0) begin
               errors++;
               $display("FAIL done_extra: got Done_1row, required none");
            end else begin
               l = len_q.pop_front();
               if (beats_in_row != l) begin
                  errors++;
                  $display("FAIL done_beats: got %0d beats before Done_1row, required %0d", beats_in_row, l);
               end
            end
            beats_in_row = 0;
            done_cnt++;
         end
         prev_done = Done_1row;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input int len, input bit last);
      Start_row  = 1'b1;
      IMAGE_SIZE = len[7:0];
      last_row   = last;
      tick();
      Start_row  = 1'b0;
      IMAGE_SIZE = 8'd0;
      last_row   = 1'b0;
   endtask

   // Builds the row's pixels, queues the expected beats and the row length, then starts the row.
   task automatic start_row(input int len, input bit last, input bit seq);
      pix.delete();
      for (int i = 0; i < len; i++) begin
         logic [DW-1:0] v;
         v = seq ? DW'(i + 1) : DW'($urandom);
         pix.push_back(v);
         exp_q.push_back({(last && (i == len - 1)), v});
      end
      len_q.push_back(len);
      pulse_start(len, last);
   endtask

   task automatic feed(input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         int b;
         if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
               din_valid = 1'b0;
               tick();
            end
         end
         din       = pix[i];
         din_valid = 1'b1;
         b         = 0;
         @(negedge clk);
         while (!din_ready && (b < 5000)) begin
            @(negedge clk);
            b++;
         end
         if (!din_ready) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout: pixel %0d not accepted, din_ready=0, required 1", i);
            din_valid = 1'b0;
            return;
         end
         push_cyc.push_back(cyc);
         tick();
      end
      din_valid = 1'b0;
   endtask

   task automatic wait_done(input int target, input int limit);
      int b = 0;
      while ((done_cnt < target) && (b < limit)) begin
         tick();
         b++;
      end
      checks++;
      if (done_cnt < target) begin
         errors++;
         $display("FAIL done_timeout: got %0d rows done, required %0d", done_cnt, target);
      end
   endtask

   initial begin
      din        = '0;
      din_valid  = 1'b0;
      Start_row  = 1'b0;
      IMAGE_SIZE = 8'd0;
      last_row   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", axis_if.tvalid, 0);
      chk("rst_tlast", axis_if.tlast, 0);
      chk("rst_tdata", axis_if.tdata, 0);
      chk("rst_din_ready", din_ready, 0);
      chk("rst_done", Done_1row, 0);
      chk("rst_busy", Busy, 0);
      Reset_n = 1'b1;
      tick();

      // 8-pixel row, 1..8 back-to-back, always ready: latency and throughput
      rdy_mode = 0;
      tick();
      hs_cyc.delete();
      push_cyc.delete();
      start_row(8, 1'b0, 1'b1);
      chk("busy_stream", Busy, 1);
      feed(8, 1'b0);
      wait_done(done_cnt + 1, 500);
      if ((hs_cyc.size() >= 8) && (push_cyc.size() >= 1)) begin
         chk("latency", hs_cyc[0] - push_cyc[0], 2);
         chk("throughput", hs_cyc[7] - hs_cyc[0], 7);
      end else begin
         chk("beat_count8", hs_cyc.size(), 8);
      end

      // Reset mid-row after 10 of 32 pixels
      tick();
      start_row(32, 1'b0, 1'b0);
      feed(10, 1'b0);
      Reset_n = 1'b0;
      #1;
      chk("mid_rst_tvalid", axis_if.tvalid, 0);
      chk("mid_rst_done", Done_1row, 0);
      chk("mid_rst_busy", Busy, 0);
      chk("mid_rst_din_ready", din_ready, 0);
      exp_q.delete();
      len_q.delete();
      beats_in_row = 0;
      repeat (2) @(posedge clk);
      #3;
      Reset_n = 1'b1;
      tick();
      start_row(32, 1'b0, 1'b0);
      feed(32, 1'b1);
      wait_done(done_cnt + 1, 2000);

      // Full 128-pixel last row with downstream stalled
      rdy_mode = 3;
      tick();
      start_row(128, 1'b1, 1'b0);
      feed(128, 1'b0);
      repeat (12) tick();
      chk("drain_din_ready", din_ready, 0);
      chk("drain_busy", Busy, 1);
      chk("stalled_beats", beats_in_row, 0);
      chk("stalled_tvalid", axis_if.tvalid, 1);
      rdy_mode = 0;
      wait_done(done_cnt + 1, 2000);

      // 200-pixel row: FIFO fills, then tready toggles
      rdy_mode = 3;
      tick();
      start_row(200, 1'b0, 1'b0);
      fork
         feed(200, 1'b0);
         begin
            repeat (150) tick();
            chk("full_din_ready", din_ready, 0);
            chk("full_beats", beats_in_row, 0);
            rdy_mode = 2;
         end
      join
      wait_done(done_cnt + 1, 2000);

      // Start_row during DRAIN and with IMAGE_SIZE=0 in IDLE are both ignored
      rdy_mode = 3;
      tick();
      start_row(10, 1'b0, 1'b0);
      feed(10, 1'b0);
      tick();
      pulse_start(5, 1'b1);
      chk("drain_start_busy", Busy, 1);
      chk("drain_start_din_ready", din_ready, 0);
      rdy_mode = 0;
      wait_done(done_cnt + 1, 500);
      repeat (3) tick();
      pulse_start(0, 1'b1);
      tick();
      chk("zero_start_busy", Busy, 0);
      chk("zero_start_din_ready", din_ready, 0);
      repeat (10) tick();
      chk("zero_start_tvalid", axis_if.tvalid, 0);

      // Two rows back-to-back, second one closes the frame
      start_row(16, 1'b0, 1'b0);
      feed(16, 1'b1);
      wait_done(done_cnt + 1, 500);
      start_row(16, 1'b1, 1'b0);
      feed(16, 1'b1);
      wait_done(done_cnt + 1, 500);

      // Random rows with random backpressure, including 1 and 255 pixels
      rdy_mode = 1;
      for (int r = 0; r < 6; r++) begin
         int  len;
         bit  last;
         len  = (r == 0) ? 1 : (r == 1) ? 255 : int'($urandom_range(1, 255));
         last = ($urandom_range(0, 1) == 1);
         wait (!Busy);
         tick();
         start_row(len, last, 1'b0);
         feed(len, 1'b1);
         wait_done(done_cnt + 1, 5000);
      end

      rdy_mode = 0;
      repeat (20) tick();
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("rows_pending", len_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
